// File: rtl/dcm_lock_supervisor.sv
// DCM/PLL bring-up and lock supervisor.
// Pulses the DCM reset, waits for a synchronised LOCKED with timeout and bounded
// retry, qualifies lock stability, then releases active-low domain resets in
// staggered order. Any lock loss after release re-asserts every domain reset
// and restarts bring-up.
module dcm_lock_supervisor #(
  parameter int NUM_DOMAINS   = 4,
  parameter int RST_PULSE     = 8,
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int STABLE_CYCLES = 64,
  parameter int STAGGER       = 4,
  parameter int RETRY_MAX     = 3
) (
  input  logic                   clkIn_i,
  input  logic                   rst_i,
  input  logic                   locked_i,
  input  logic                   retryReq_i,
  output logic                   rstDCM_o,
  output logic [NUM_DOMAINS-1:0] domainRstn_o,
  output logic                   running_o,
  output logic                   fail_o,
  output logic [3:0]             retryCount_o,
  output logic [7:0]             lossCount_o
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int REL_SPAN = (NUM_DOMAINS - 1) * STAGGER + 1;
  localparam int CNT_MAX  = max2(max2(RST_PULSE, LOCK_TIMEOUT), max2(STABLE_CYCLES, REL_SPAN));
  localparam int CW       = $clog2(CNT_MAX + 1);

  // Last counter value of each timed phase; the phase ends on the edge that sees it.
  localparam logic [CW-1:0] PULSE_LAST   = CW'(RST_PULSE - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_N     = CW'(STABLE_CYCLES);
  localparam logic [3:0]    RETRY_LIMIT  = 4'(RETRY_MAX);

  typedef enum logic [2:0] {
    S_RST_DCM,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   lock_meta_q, lock_s_q;
  logic                   rstDCM_q, rstDCM_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   running_q, running_d;
  logic                   fail_q, fail_d;
  logic [3:0]             retry_q, retry_d;
  logic [7:0]             loss_q, loss_d;

  logic [CW-1:0]          cnt_inc;
  logic [3:0]             retry_inc;
  logic [NUM_DOMAINS-1:0] rise_at;

  assign cnt_inc   = cnt_q + CW'(1);
  assign retry_inc = retry_q + 4'd1;

  // Domain gi is due when the release counter reaches gi*STAGGER; bit 0 is set on entry.
  for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_rise
    assign rise_at[gi] = (cnt_inc == CW'(gi * STAGGER));
  end

  // Two-flop synchroniser for the asynchronous LOCKED input.
  always_ff @(posedge clkIn_i) begin
    if (rst_i) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= locked_i;
      lock_s_q    <= lock_meta_q;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clkIn_i) begin
    if (rst_i) begin
      state_q   <= S_RST_DCM;
      cnt_q     <= '0;
      rstDCM_q  <= 1'b1;
      dom_q     <= '0;
      running_q <= 1'b0;
      fail_q    <= 1'b0;
      retry_q   <= 4'd0;
      loss_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rstDCM_q  <= rstDCM_d;
      dom_q     <= dom_d;
      running_q <= running_d;
      fail_q    <= fail_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rstDCM_d  = rstDCM_q;
    dom_d     = dom_q;
    running_d = running_q;
    fail_d    = fail_q;
    retry_d   = retry_q;
    loss_d    = loss_q;

    unique case (state_q)
      S_RST_DCM: begin
        rstDCM_d  = 1'b1;
        dom_d     = '0;
        running_d = 1'b0;
        if (cnt_q == PULSE_LAST) begin
          state_d  = S_WAIT_LOCK;
          cnt_d    = '0;
          rstDCM_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d  = retry_inc;
          cnt_d    = '0;
          rstDCM_d = 1'b1;
          if (retry_inc == RETRY_LIMIT) begin
            state_d = S_FAIL;
            fail_d  = 1'b1;
          end else begin
            state_d = S_RST_DCM;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_STABLE: begin
        // A drop on the completing cycle is checked first, so it wins.
        if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_inc == STABLE_N) begin
          state_d  = S_RELEASE;
          cnt_d    = '0;
          dom_d[0] = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_RELEASE, S_RUN: begin
        if (!lock_s_q) begin
          state_d   = S_RST_DCM;
          cnt_d     = '0;
          rstDCM_d  = 1'b1;
          dom_d     = '0;
          running_d = 1'b0;
          retry_d   = 4'd0;
          loss_d    = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
        end else if (state_q == S_RELEASE) begin
          if (&dom_q) begin
            state_d   = S_RUN;
            cnt_d     = '0;
            running_d = 1'b1;
            retry_d   = 4'd0;
          end else begin
            dom_d = dom_q | rise_at;
            cnt_d = cnt_inc;
          end
        end
      end

      S_FAIL: begin
        rstDCM_d = 1'b1;
        dom_d    = '0;
        fail_d   = 1'b1;
        if (retryReq_i) begin
          state_d = S_RST_DCM;
          cnt_d   = '0;
          fail_d  = 1'b0;
          retry_d = 4'd0;
        end
      end

      default: begin
        state_d   = S_RST_DCM;
        cnt_d     = '0;
        rstDCM_d  = 1'b1;
        dom_d     = '0;
        running_d = 1'b0;
      end
    endcase
  end

  assign rstDCM_o     = rstDCM_q;
  assign domainRstn_o = dom_q;
  assign running_o    = running_q;
  assign fail_o       = fail_q;
  assign retryCount_o = retry_q;
  assign lossCount_o  = loss_q;

endmodule

// File: tb/tb_dcm_lock_supervisor.sv
// Bench for dcm_lock_supervisor: a default-parameter instance checked through a
// cycle-indexed expectation queue, plus a minimal instance (one domain, short
// timing) for the single-release and lossCount saturation cases.
module tb_dcm_lock_supervisor;

  localparam int ND = 4, RP = 8, LT = 1024, SC = 64, ST = 4, RM = 3;
  localparam int LK = 20;            // edge at which locked is first sampled high

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, locked = 1'b0, retry_req = 1'b0;
  logic       rst_dcm, running, fail;
  logic [3:0] dom, retry_cnt;
  logic [7:0] loss_cnt;

  logic       rst2 = 1'b1, locked2 = 1'b1, retry2 = 1'b0;
  logic       rst_dcm2, running2, fail2;
  logic [0:0] dom2;
  logic [3:0] retry_cnt2;
  logic [7:0] loss_cnt2;

  dcm_lock_supervisor #(
    .NUM_DOMAINS(ND), .RST_PULSE(RP), .LOCK_TIMEOUT(LT),
    .STABLE_CYCLES(SC), .STAGGER(ST), .RETRY_MAX(RM)
  ) dut (
    .clkIn_i(clk), .rst_i(rst), .locked_i(locked), .retryReq_i(retry_req),
    .rstDCM_o(rst_dcm), .domainRstn_o(dom), .running_o(running), .fail_o(fail),
    .retryCount_o(retry_cnt), .lossCount_o(loss_cnt)
  );

  dcm_lock_supervisor #(
    .NUM_DOMAINS(1), .RST_PULSE(3), .LOCK_TIMEOUT(16),
    .STABLE_CYCLES(1), .STAGGER(1), .RETRY_MAX(3)
  ) u_small (
    .clkIn_i(clk), .rst_i(rst2), .locked_i(locked2), .retryReq_i(retry2),
    .rstDCM_o(rst_dcm2), .domainRstn_o(dom2), .running_o(running2), .fail_o(fail2),
    .retryCount_o(retry_cnt2), .lossCount_o(loss_cnt2)
  );

  // Edge index since reset release: edge 0 is the first rising edge with rst=0.
  int ecnt = 0;
  always @(posedge clk) begin
    if (rst) ecnt <= -1;
    else     ecnt <= ecnt + 1;
  end

  typedef struct {
    int         cyc;   // outputs are compared just after this edge
    string      name;
    logic       rd;
    logic [3:0] dm;
    logic       run;
    logic       fl;
    logic [3:0] rc;
    logic [7:0] lc;
  } exp_t;

  typedef struct {
    int         cyc;   // locked is driven so that this edge samples lk
    logic       lk;
    logic       rd;
    logic [3:0] dm;
    logic       run;
  } vec_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end else begin
      $display("ok   %s: %0h", nm, got);
    end
  endtask

  function automatic void push(input int c, input string nm, input logic r, input logic [3:0] d,
                               input logic run, input logic f, input logic [3:0] rc, input logic [7:0] lc);
    exp_t e;
    e.cyc = c; e.name = nm; e.rd = r; e.dm = d; e.run = run; e.fl = f; e.rc = rc; e.lc = lc;
    sb_q.push_back(e);
  endfunction

  // Pops every expectation that is due and compares the packed output vector.
  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= ecnt) begin
        e = sb_q.pop_front();
        if (e.cyc < ecnt) begin
          check($sformatf("%s missed@%0d", e.name, e.cyc), 32'(ecnt), 32'(e.cyc));
        end else begin
          check($sformatf("%s @%0d {rd,dom,run,fail,retry,loss}", e.name, e.cyc),
                32'({rst_dcm, dom, running, fail, retry_cnt, loss_cnt}),
                32'({e.rd, e.dm, e.run, e.fl, e.rc, e.lc}));
        end
      end
    end
  endtask

  // Returns just after edge e-1, so values driven now are sampled at edge e.
  task automatic at_edge(input int e);
    int g = 0;
    while (ecnt != e - 1 && g < 5000) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 5000) check("at_edge bound", 32'(ecnt), 32'(e - 1));
  endtask

  task automatic drain();
    int g = 0;
    while (sb_q.size() > 0 && g < 5000) begin
      @(posedge clk);
      g++;
    end
    #1;
    if (sb_q.size() > 0) begin
      check("drain bound", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  // Asserts rst for two edges and checks the reset values after the first.
  task automatic do_reset(input string nm);
    rst = 1'b1;
    retry_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({nm, " reset values"}, 32'({rst_dcm, dom, running, fail, retry_cnt, loss_cnt}),
          32'({1'b1, 4'h0, 1'b0, 1'b0, 4'd0, 8'd0}));
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_tests();
    vec_t tbl [12];
    int   rel0, d, r2, to1, f1, to2, f2, to3, rq, g;

    // Bring-up timeline: locked sampled high at LK, seen by the decision logic at LK+2.
    rel0 = LK + 2 + SC;
    tbl[0]  = '{0,             1'b0, 1'b1, 4'h0, 1'b0};
    tbl[1]  = '{RP - 2,        1'b0, 1'b1, 4'h0, 1'b0};
    tbl[2]  = '{RP - 1,        1'b0, 1'b0, 4'h0, 1'b0};
    tbl[3]  = '{LK,            1'b1, 1'b0, 4'h0, 1'b0};
    tbl[4]  = '{rel0 - 1,      1'b1, 1'b0, 4'h0, 1'b0};
    tbl[5]  = '{rel0,          1'b1, 1'b0, 4'h1, 1'b0};
    tbl[6]  = '{rel0 + ST - 1, 1'b1, 1'b0, 4'h1, 1'b0};
    tbl[7]  = '{rel0 + ST,     1'b1, 1'b0, 4'h3, 1'b0};
    tbl[8]  = '{rel0 + 2*ST,   1'b1, 1'b0, 4'h7, 1'b0};
    tbl[9]  = '{rel0 + 3*ST-1, 1'b1, 1'b0, 4'h7, 1'b0};
    tbl[10] = '{rel0 + 3*ST,   1'b1, 1'b0, 4'hF, 1'b0};
    tbl[11] = '{rel0 + 3*ST+1, 1'b1, 1'b0, 4'hF, 1'b1};

    // 1: normal bring-up
    locked = 1'b0;
    do_reset("s1");
    foreach (tbl[i]) push(tbl[i].cyc, "s1", tbl[i].rd, tbl[i].dm, tbl[i].run, 1'b0, 4'd0, 8'd0);
    foreach (tbl[i]) begin
      at_edge(tbl[i].cyc);
      locked = tbl[i].lk;
    end
    drain();

    // 2: lock never arrives -> two retries, then FAIL; retryReq only acts in FAIL
    locked = 1'b0;
    do_reset("s2");
    to1 = (RP - 1) + LT; f1 = to1 + RP;
    to2 = f1 + LT;       f2 = to2 + RP;
    to3 = f2 + LT;       rq = to3 + 5;
    push(to1 - 1,    "s2 before timeout1", 1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 8'd0);
    push(to1,        "s2 timeout1",        1'b1, 4'h0, 1'b0, 1'b0, 4'd1, 8'd0);
    push(f1 - 1,     "s2 pulse1 end",      1'b1, 4'h0, 1'b0, 1'b0, 4'd1, 8'd0);
    push(f1,         "s2 pulse1 off",      1'b0, 4'h0, 1'b0, 1'b0, 4'd1, 8'd0);
    push(f1 + 1,     "s2 retryReq ignored",1'b0, 4'h0, 1'b0, 1'b0, 4'd1, 8'd0);
    push(to2,        "s2 timeout2",        1'b1, 4'h0, 1'b0, 1'b0, 4'd2, 8'd0);
    push(f2,         "s2 pulse2 off",      1'b0, 4'h0, 1'b0, 1'b0, 4'd2, 8'd0);
    push(to3 - 1,    "s2 before timeout3", 1'b0, 4'h0, 1'b0, 1'b0, 4'd2, 8'd0);
    push(to3,        "s2 fail entered",    1'b1, 4'h0, 1'b0, 1'b1, 4'd3, 8'd0);
    push(rq - 1,     "s2 fail held",       1'b1, 4'h0, 1'b0, 1'b1, 4'd3, 8'd0);
    push(rq,         "s2 retry accepted",  1'b1, 4'h0, 1'b0, 1'b0, 4'd0, 8'd0);
    push(rq + RP - 1,"s2 retry pulse end", 1'b1, 4'h0, 1'b0, 1'b0, 4'd0, 8'd0);
    push(rq + RP,    "s2 retry pulse off", 1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 8'd0);
    at_edge(f1 + 1); retry_req = 1'b1;
    at_edge(f1 + 2); retry_req = 1'b0;
    at_edge(rq);     retry_req = 1'b1;
    at_edge(rq + 1); retry_req = 1'b0;
    drain();

    // 3: one-cycle lock drop in RUN -> all domains re-asserted, full bring-up again
    locked = 1'b0;
    do_reset("s3");
    d  = 110;
    r2 = d + 11 + SC;
    push(rel0 + 3*ST + 1, "s3 run",          1'b0, 4'hF, 1'b1, 1'b0, 4'd0, 8'd0);
    push(d + 1,           "s3 drop not seen",1'b0, 4'hF, 1'b1, 1'b0, 4'd0, 8'd0);
    push(d + 2,           "s3 domains reset",1'b1, 4'h0, 1'b0, 1'b0, 4'd0, 8'd1);
    push(d + 2 + RP - 1,  "s3 pulse end",    1'b1, 4'h0, 1'b0, 1'b0, 4'd0, 8'd1);
    push(d + 2 + RP,      "s3 pulse off",    1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 8'd1);
    push(r2 - 1,          "s3 pre-release",  1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 8'd1);
    push(r2,              "s3 bit0",         1'b0, 4'h1, 1'b0, 1'b0, 4'd0, 8'd1);
    push(r2 + 3*ST,       "s3 bit3",         1'b0, 4'hF, 1'b0, 1'b0, 4'd0, 8'd1);
    push(r2 + 3*ST + 1,   "s3 run again",    1'b0, 4'hF, 1'b1, 1'b0, 4'd0, 8'd1);
    at_edge(LK);    locked = 1'b1;
    at_edge(d);     locked = 1'b0;
    at_edge(d + 1); locked = 1'b1;
    drain();

    // 4: glitch during STABLE at count 40 restarts qualification
    locked = 1'b0;
    do_reset("s4");
    r2 = 61 + 3 + SC;
    push(rel0,         "s4 no early release", 1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 8'd0);
    push(r2 - 1,       "s4 still qualifying", 1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 8'd0);
    push(r2,           "s4 bit0",             1'b0, 4'h1, 1'b0, 1'b0, 4'd0, 8'd0);
    push(r2 + 3*ST,    "s4 bit3",             1'b0, 4'hF, 1'b0, 1'b0, 4'd0, 8'd0);
    push(r2 + 3*ST + 1,"s4 run",              1'b0, 4'hF, 1'b1, 1'b0, 4'd0, 8'd0);
    at_edge(LK); locked = 1'b1;
    at_edge(61); locked = 1'b0;
    at_edge(62); locked = 1'b1;
    drain();

    // 5: rst with two domains released, then retryReq in RUN has no effect
    locked = 1'b0;
    do_reset("s5");
    push(rel0 + ST + 1, "s5 two released", 1'b0, 4'h3, 1'b0, 1'b0, 4'd0, 8'd0);
    at_edge(LK); locked = 1'b1;
    at_edge(rel0 + ST + 2);
    do_reset("s5 mid-release");
    // locked stays high through reset: seen at edge RP, STABLE completes SC edges later.
    r2 = RP + SC;
    push(r2,            "s5 bit0",            1'b0, 4'h1, 1'b0, 1'b0, 4'd0, 8'd0);
    push(r2 + 3*ST + 1, "s5 run",             1'b0, 4'hF, 1'b1, 1'b0, 4'd0, 8'd0);
    push(90,            "s5 retryReq in RUN", 1'b0, 4'hF, 1'b1, 1'b0, 4'd0, 8'd0);
    push(95,            "s5 RUN held",        1'b0, 4'hF, 1'b1, 1'b0, 4'd0, 8'd0);
    at_edge(90); retry_req = 1'b1;
    at_edge(91); retry_req = 1'b0;
    drain();

    // 6: single domain, minimal timing, lossCount saturation
    @(posedge clk); #1;
    rst2 = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("s6 single release {dom,run}", 32'({dom2, running2}), 32'({1'b1, 1'b0}));
    @(posedge clk);
    @(negedge clk);
    check("s6 running", 32'({dom2, running2}), 32'({1'b1, 1'b1}));
    for (int i = 1; i <= 256; i++) begin
      @(posedge clk); #1; locked2 = 1'b0;
      @(posedge clk); #1; locked2 = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      if (i == 1) check("s6 loss drops domain", 32'({dom2, running2}), 32'd0);
      g = 0;
      while (!running2 && g < 50) begin
        @(negedge clk);
        g++;
      end
      if (g >= 50) begin
        check($sformatf("s6 rebring-up %0d running", i), 32'(running2), 32'd1);
        break;
      end
      if (i == 1)   check("s6 lossCount 1",         32'(loss_cnt2), 32'd1);
      if (i == 255) check("s6 lossCount 255",       32'(loss_cnt2), 32'd255);
      if (i == 256) check("s6 lossCount saturated", 32'(loss_cnt2), 32'd255);
    end
  endtask

  initial begin
    fork
      monitor_loop();
      begin
        run_tests();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    join
  end

endmodule
